// File: rtl/mux8x1_rr_pkg.sv
// Lane encoding shared by the 8:1 round-robin mux and its 1x8 demux peer.
// Both sides must agree on lane count and select width.
package mux8x1_rr_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_t;
  typedef logic [LANES-1:0] lane_vec_t;

  function automatic lane_t lane_next(lane_t l);
    return l + lane_t'(1);
  endfunction
endpackage

// File: rtl/mux8x1_rr_if.sv
// Lane-side and output-side valid/ready bundle of the 8:1 mux.
// slave is the mux view, master is the driver/consumer view.
interface mux8x1_rr_if
  import mux8x1_rr_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  lane_vec_t              in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  lane_vec_t              in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  lane_t                  out_sel;
  logic                   out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );
endinterface

// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin request picker: first requester at or after ptr wins.
// Pure combinational; the caller owns the pointer.
module rr_arbiter8
  import mux8x1_rr_pkg::*;
(
  input  lane_vec_t req_i,
  input  lane_t     ptr_i,
  output lane_vec_t grant_o,
  output lane_t     gidx_o,
  output logic      any_o
);
  always_comb begin
    gidx_o = '0;
    any_o  = 1'b0;
    // Walk from the far end so the closest offset overwrites last.
    for (int off = LANES - 1; off >= 0; off--) begin
      if (req_i[ptr_i + lane_t'(off)]) begin
        gidx_o = ptr_i + lane_t'(off);
        any_o  = 1'b1;
      end
    end
    grant_o = any_o ? (lane_vec_t'(1) << gidx_o) : '0;
  end
endmodule

// File: rtl/mux8x1_rr.sv
// Eight-lane round-robin merge onto one registered, lane-tagged stream.
// Holds the output register, the priority pointer and in_ready gating.
module mux8x1_rr
  import mux8x1_rr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  mux8x1_rr_if.slave  bus
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  lane_t            out_sel_q, out_sel_d;
  lane_t            ptr_q, ptr_d;

  lane_vec_t grant;
  lane_t     gidx;
  logic      any;
  logic      can_load;
  logic      xfer;

  rr_arbiter8 u_arb (
    .req_i   (bus.in_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .gidx_o  (gidx),
    .any_o   (any)
  );

  assign can_load = !out_valid_q || bus.out_ready;
  assign xfer     = any && can_load && !rst;

  assign bus.in_ready  = xfer ? grant : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gidx*WIDTH +: WIDTH];
      out_sel_d   = gidx;
      ptr_d       = lane_next(gidx);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end
endmodule
